// File: rtl/fifo_pkg.sv
// Shared FIFO word definitions for the write-side packer and its neighbours.
package fifo_pkg;

    localparam int FIFO_DW     = 128;
    localparam int FIFO_BEAT_W = 32;

    typedef logic [FIFO_DW-1:0] fifo_word_t;

    // Lane counter width; a single-lane packer still needs a 1-bit counter.
    function automatic int lane_cnt_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_packer.sv
// Packs DIN_W-bit stream beats into DOUT_W-bit FIFO words through an acc (filling) and hold (awaiting FIFO) stage.
// Optional FIFO_PACKER_ALMFULL_EN: i_alm_full also throttles o_ready.
module fifo_wr_packer
    import fifo_pkg::*;
#(
    parameter int DIN_W  = FIFO_BEAT_W,
    parameter int DOUT_W = FIFO_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DIN_W-1:0]  i_data,
    input  logic              i_last,
    output logic              o_wren,
    output logic [DOUT_W-1:0] o_wrdata,
    input  logic              i_full,
    input  logic              i_alm_full,
    output logic              o_busy
);

    localparam int RATIO = DOUT_W / DIN_W;
    localparam int CNT_W = lane_cnt_w(RATIO);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    if (DOUT_W % DIN_W != 0) begin : g_width_chk
        $error("fifo_wr_packer: DOUT_W must be a multiple of DIN_W");
    end

    logic [CNT_W-1:0]  r_lane_cnt;
    logic [DOUT_W-1:0] r_acc;
    logic              r_acc_full;
    logic [DOUT_W-1:0] r_hold;
    logic              r_hold_vld;

    logic              w_accept;
    logic              w_close;
    logic              w_hold_free;
    logic [DOUT_W-1:0] w_merged;

`ifdef FIFO_PACKER_ALMFULL_EN
    always_comb begin
        o_ready = !r_acc_full && !i_alm_full;
    end
`else
    logic w_unused_alm;
    assign w_unused_alm = i_alm_full;

    always_comb begin
        o_ready = !r_acc_full;
    end
`endif

    always_comb begin
        o_wren = r_hold_vld && !i_full;
    end

    assign o_wrdata    = r_hold;
    assign o_busy      = r_hold_vld || r_acc_full || (r_lane_cnt != '0);
    assign w_accept    = i_valid && o_ready;
    assign w_close     = w_accept && (i_last || (r_lane_cnt == LAST_LANE));
    assign w_hold_free = !r_hold_vld || o_wren;

    // Accumulator with the incoming beat dropped into its lane; upper lanes are still zero.
    always_comb begin
        w_merged = r_acc;
        for (int k = 0; k < RATIO; k++) begin
            if (r_lane_cnt == CNT_W'(k)) begin
                w_merged[k*DIN_W +: DIN_W] = i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_acc      <= '0;
            r_acc_full <= 1'b0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lane_cnt <= w_close ? '0 : r_lane_cnt + CNT_W'(1);
            end

            // A stalled closed word leaves acc as soon as hold frees up.
            if (r_acc_full) begin
                if (w_hold_free) begin
                    r_acc      <= '0;
                    r_acc_full <= 1'b0;
                end
            end else if (w_accept) begin
                if (!w_close) begin
                    r_acc <= w_merged;
                end else if (w_hold_free) begin
                    r_acc <= '0;
                end else begin
                    r_acc      <= w_merged;
                    r_acc_full <= 1'b1;
                end
            end

            if (r_acc_full && w_hold_free) begin
                r_hold     <= r_acc;
                r_hold_vld <= 1'b1;
            end else if (w_close && w_hold_free) begin
                r_hold     <= w_merged;
                r_hold_vld <= 1'b1;
            end else if (o_wren) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Randomised + directed bench for fifo_wr_packer with a lane-queue reference model and write scoreboard.
module tb_fifo_wr_packer;

    localparam int DW    = 32;
    localparam int OW    = 128;
    localparam int RATIO = OW / DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data = '0;
    logic          i_last = 1'b0;
    logic          o_wren;
    logic [OW-1:0] o_wrdata;
    logic          i_full = 1'b0;
    logic          i_alm_full = 1'b0;
    logic          o_busy;

    fifo_wr_packer #(.DIN_W(DW), .DOUT_W(OW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_last(i_last), .o_wren(o_wren), .o_wrdata(o_wrdata),
        .i_full(i_full), .i_alm_full(i_alm_full), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_wr  = 0;
    bit rnd   = 1'b0;

    logic [DW-1:0] lanes[$];
    logic [OW-1:0] exp_q[$];
    int            wr_cyc[$];

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: collect accepted beats, emit a zero-padded word on last or when RATIO beats arrive.
    always @(posedge clk) begin
        if (rst) begin
            lanes.delete();
        end else if (i_valid && o_ready) begin
            lanes.push_back(i_data);
            if (i_last || lanes.size() == RATIO) begin
                logic [OW-1:0] w;
                w = '0;
                foreach (lanes[k]) w[k*DW +: DW] = lanes[k];
                exp_q.push_back(w);
                lanes.delete();
            end
        end
    end

    // Monitor: every FIFO write is checked against the oldest expected word.
    always @(negedge clk) begin
        if (i_full) chk("wren_while_full", {127'd0, o_wren}, '0);
        if (o_wren) begin
            n_wr++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", o_wrdata, '1);
            end else begin
                chk("wrdata", o_wrdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) begin
            i_full     = ($urandom_range(0, 9) < 3);
            i_alm_full = ($urandom_range(0, 9) < 2);
        end
    endtask

    // Present one beat and hold it until accepted; leaves i_valid asserted for back-to-back use.
    task automatic send(input logic [DW-1:0] d, input logic l);
        bit rdy;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            rdy = o_ready;
            step();
            if (rdy) return;
        end
        chk("send_timeout", 128'd0, 128'd1);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_last  = 1'b0;
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic drain();
        i_full = 1'b0;
        i_alm_full = 1'b0;
        i_valid = 1'b0;
        for (int c = 0; c < 50 && (exp_q.size() != 0 || o_busy); c++) step();
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        int t0;
        int n_acc;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",  {127'd0, o_ready}, 128'd1);
        chk("rst_wren",   {127'd0, o_wren},  128'd0);
        chk("rst_wrdata", o_wrdata,          128'd0);
        chk("rst_busy",   {127'd0, o_busy},  128'd0);
        step();

        // 1: full word
        send(32'h11111111, 0); send(32'h22222222, 0);
        send(32'h33333333, 0); send(32'h44444444, 0);
        idle(3);
        chk("t1_word", (n_wr == 1) ? o_wrdata : 128'd0,
            128'h44444444_33333333_22222222_11111111);

        // 2: partial flush, next word starts at lane 0
        send(32'hA, 0); send(32'hB, 1);
        idle(2);
        chk("t2_word", o_wrdata, 128'h0000000B_0000000A);
        send(32'h5, 0); send(32'h6, 0); send(32'h7, 0); send(32'h8, 0);
        idle(2);
        chk("t2_next", o_wrdata, 128'h00000008_00000007_00000006_00000005);

        // 3: back-pressure
        n_wr = 0;
        i_full = 1'b1;
        for (int b = 0; b < 8; b++) send(32'h300 + b, 0);
        i_data = 32'h308; i_last = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_ready) n_acc++;
            step();
        end
        chk("t3_stalled", 128'(n_acc), 128'd0);
        chk("t3_no_wren", 128'(n_wr), 128'd0);
        i_full = 1'b0;
        for (int b = 8; b < 12; b++) send(32'h300 + b, 0);
        idle(4);
        chk("t3_words", 128'(n_wr), 128'd3);

        // 4: sustained streaming
        wr_cyc.delete();
        t0 = cyc;
        for (int b = 0; b < 16; b++) send($urandom, 0);
        chk("t4_no_stall", 128'(cyc - t0), 128'd16);
        idle(3);
        chk("t4_pulses", 128'(wr_cyc.size()), 128'd4);
        for (int k = 1; k < wr_cyc.size(); k++)
            chk("t4_spacing", 128'(wr_cyc[k] - wr_cyc[k-1]), 128'd4);

        // 5: reset mid-word
        n_wr = 0;
        send(32'hDEAD, 0); send(32'hBEEF, 0);
        i_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", {127'd0, o_busy}, 128'd0);
        step(); step();
        chk("t5_no_write", 128'(n_wr), 128'd0);
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        idle(2);
        chk("t5_word", o_wrdata, 128'h00000004_00000003_00000002_00000001);

        // 6: almost-full throttle
        i_full = 1'b1;
        for (int b = 0; b < 4; b++) send(32'h600 + b, 0);
        i_valid = 1'b0;
        i_alm_full = 1'b1;
        i_full = 1'b0;
        @(negedge clk);
`ifdef FIFO_PACKER_ALMFULL_EN
        chk("t6_ready", {127'd0, o_ready}, 128'd0);
`else
        chk("t6_ready", {127'd0, o_ready}, 128'd1);
`endif
        chk("t6_held_writes", {127'd0, o_wren}, 128'd1);
        step();
        i_alm_full = 1'b0;
        idle(2);

        // Random phase
        rnd = 1'b1;
        for (int b = 0; b < 300; b++) begin
            send($urandom, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        send($urandom, 1);
        rnd = 1'b0;
        drain();
        @(negedge clk);
        chk("end_busy", {127'd0, o_busy}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
